simple_ram_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer in front of the single-port `SimpleRam` debug buffer. It shares the RAM between requester 0 (host-bus bridge from the AT91 SMC side) and requester 1 (on-FPGA debug capture logic). It serialises their accesses, drives the RAM's `wr_i`/`rd_i`/`addr_i`/`data_i`, and captures the RAM's registered, tri-stated read data. Each requester gets a simple req/ack handshake with a one-cycle ack pulse.

---
 rtl/simple_ram_arbiter.sv | 137 +++++++++++++
 tb/tb_simple_ram_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/simple_ram_arbiter.sv
// simple_ram_arbiter
//
// Round-robin arbiter and access sequencer that shares one single-port RAM
// between two requesters: port 0 is the host-bus bridge and port 1 is the
// on-FPGA debug capture logic. Each access is serialised as
// IDLE -> WR -> RESP (write) or IDLE -> RD1 -> RD2 -> RESP (read). In RESP
// the winner gets a one-cycle ack.
//
// Ports:
//   clk_i, reset_n_i         clock shared with the RAM; async active-low reset
//   pN_req_i                 access request, held until ack
//   pN_we_i                  1 = write, 0 = read (stable while req is high)
//   pN_addr_i, pN_wdata_i    word address / write data (stable while req is high)
//   pN_ack_o                 one-cycle completion pulse
//   pN_rdata_o               last read result of port N, valid from its ack onward
//   ram_wr_o, ram_rd_o       RAM strobes, registered, never both high
//   ram_addr_o, ram_data_o   latched address / write data of the current grant
//   ram_data_i               RAM read data, tri-stated while ram_rd_o is low
//   busy_o                   high whenever the sequencer is not in IDLE
module simple_ram_arbiter #(
    parameter int LOG2_SIZE  = 5,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  p0_req_i,
    input  logic                  p0_we_i,
    input  logic [LOG2_SIZE-1:0]  p0_addr_i,
    input  logic [DATA_WIDTH-1:0] p0_wdata_i,
    output logic                  p0_ack_o,
    output logic [DATA_WIDTH-1:0] p0_rdata_o,
    input  logic                  p1_req_i,
    input  logic                  p1_we_i,
    input  logic [LOG2_SIZE-1:0]  p1_addr_i,
    input  logic [DATA_WIDTH-1:0] p1_wdata_i,
    output logic                  p1_ack_o,
    output logic [DATA_WIDTH-1:0] p1_rdata_o,
    output logic                  ram_wr_o,
    output logic                  ram_rd_o,
    output logic [LOG2_SIZE-1:0]  ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    output logic                  busy_o
);

    typedef enum logic [2:0] {IDLE, WR, RD1, RD2, RESP} state_t;

    state_t                  state_reg, state_next;
    logic                    id_reg;         // winner of the current access
    logic                    last_reg;       // port granted most recently
    logic                    take;           // a grant happens at this edge
    logic                    win;            // port that would win in IDLE
    logic                    sel_we;
    logic [LOG2_SIZE-1:0]    sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [LOG2_SIZE-1:0]    ram_addr_reg;
    logic [DATA_WIDTH-1:0]   ram_data_reg;
    logic                    ram_wr_reg, ram_rd_reg, busy_reg;
    logic [1:0]              ack_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg [2];

    // On a tie, the port that was not granted last wins. Otherwise the
    // single requester wins. (With no request, win is a don't-care.)
    assign win       = (p0_req_i && p1_req_i) ? ~last_reg : p1_req_i;
    assign sel_we    = win ? p1_we_i    : p0_we_i;
    assign sel_addr  = win ? p1_addr_i  : p0_addr_i;
    assign sel_wdata = win ? p1_wdata_i : p0_wdata_i;

    always_comb begin
        state_next = state_reg;
        take       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (p0_req_i || p1_req_i) begin
                    take       = 1'b1;
                    state_next = sel_we ? WR : RD1;
                end
            end
            WR:      state_next = RESP;
            RD1:     state_next = RD2;
            RD2:     state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes, busy and acks are registered from the next state, so each one
    // is high exactly while the FSM sits in the corresponding state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg    <= IDLE;
            id_reg       <= 1'b0;
            last_reg     <= 1'b1;
            ram_addr_reg <= '0;
            ram_data_reg <= '0;
            ram_wr_reg   <= 1'b0;
            ram_rd_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            ack_reg      <= '0;
            for (int i = 0; i < 2; i++) begin
                rdata_reg[i] <= '0;
            end
        end else begin
            state_reg  <= state_next;
            ram_wr_reg <= (state_next == WR);
            ram_rd_reg <= (state_next == RD1) || (state_next == RD2);
            busy_reg   <= (state_next != IDLE);
            if (take) begin
                id_reg       <= win;
                ram_addr_reg <= sel_addr;
                ram_data_reg <= sel_wdata;
            end
            if (state_reg == RESP) begin
                last_reg <= id_reg;
            end
            for (int i = 0; i < 2; i++) begin
                ack_reg[i] <= (state_next == RESP) && (id_reg == 1'(i));
                // ram_data_i is only driven while rd is held high, so it is
                // sampled solely at the edge that ends RD2.
                if ((state_reg == RD2) && (id_reg == 1'(i))) begin
                    rdata_reg[i] <= ram_data_i;
                end
            end
        end
    end

    assign p0_ack_o   = ack_reg[0];
    assign p1_ack_o   = ack_reg[1];
    assign p0_rdata_o = rdata_reg[0];
    assign p1_rdata_o = rdata_reg[1];
    assign ram_wr_o   = ram_wr_reg;
    assign ram_rd_o   = ram_rd_reg;
    assign ram_addr_o = ram_addr_reg;
    assign ram_data_o = ram_data_reg;
    assign busy_o     = busy_reg;

endmodule

// File: tb/tb_simple_ram_arbiter.sv
// Directed bench for simple_ram_arbiter with a behavioural SimpleRam model
// (registered read, output X whenever rd is low).
module tb_simple_ram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        p0_req, p0_we, p0_ack, p1_req, p1_we, p1_ack;
    logic [4:0]  p0_addr, p1_addr, ram_addr;
    logic [15:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, ram_wdata, ram_q, ram_bus;
    logic        ram_wr, ram_rd, busy;

    simple_ram_arbiter #(.LOG2_SIZE(5), .DATA_WIDTH(16)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
        .p0_ack_o(p0_ack), .p0_rdata_o(p0_rdata),
        .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
        .p1_ack_o(p1_ack), .p1_rdata_o(p1_rdata),
        .ram_wr_o(ram_wr), .ram_rd_o(ram_rd), .ram_addr_o(ram_addr), .ram_data_o(ram_wdata),
        .ram_data_i(ram_bus), .busy_o(busy)
    );

    // RAM model: not reset, registered read, undriven (X) output when rd is low
    logic [15:0] mem [32];
    initial for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_wdata;
        if (ram_rd) ram_q <= mem[ram_addr];
    end
    assign ram_bus = ram_rd ? ram_q : 16'hxxxx;

    int n_cmp = 0;
    int n_bad = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Contention monitor: strobes and acks must be mutually exclusive
    always @(negedge clk) begin
        if (mon_en) begin
            chk("wr_and_rd", {63'd0, ram_wr & ram_rd}, 64'd0);
            chk("dual_ack", {63'd0, p0_ack & p1_ack}, 64'd0);
        end
    end

    task automatic set_req(input int port, input logic req, input logic we,
                           input logic [4:0] a, input logic [15:0] d);
        if (port == 0) begin
            p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
        end else begin
            p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
        end
    endtask

    function automatic logic get_ack(input int port);
        return (port == 0) ? p0_ack : p1_ack;
    endfunction

    function automatic logic [15:0] get_rdata(input int port);
        return (port == 0) ? p0_rdata : p1_rdata;
    endfunction

    // Single-port transaction: request raised in an IDLE cycle, sampled at edge E
    task automatic do_txn(input int port, input logic we, input logic [4:0] a,
                          input logic [15:0] d, input logic [15:0] exp_rdata);
        int k, nwr, nrd;
        logic got;
        @(negedge clk);
        set_req(port, 1'b1, we, a, d);
        @(posedge clk);
        k = 0; nwr = 0; nrd = 0; got = 1'b0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            nwr += int'(ram_wr);
            nrd += int'(ram_rd);
            got = get_ack(port);
        end
        chk("latency", 64'(k), we ? 64'd2 : 64'd3);
        chk("other_ack", {63'd0, get_ack(1 - port)}, 64'd0);
        chk("wr_pulses", 64'(nwr), we ? 64'd1 : 64'd0);
        chk("rd_cycles", 64'(nrd), we ? 64'd0 : 64'd2);
        chk("addr_hold", {59'd0, ram_addr}, {59'd0, a});
        if (!we) chk("rdata", {48'd0, get_rdata(port)}, {48'd0, exp_rdata});
        set_req(port, 1'b0, 1'b0, 5'd0, 16'd0);
        $display("txn p%0d %s addr=%0d wdata=%h rdata=%h ack_after=%0d",
                 port, we ? "wr" : "rd", a, d, get_rdata(port), k);
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [4:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_p0;   // p0_rdata_o after the transaction
        logic [15:0] exp_p1;   // p1_rdata_o after the transaction
    } vec_t;

    vec_t vecs [8];

    initial begin
        int c0, c1, k, i0, i1, exp_port, nack;
        logic [15:0] r0;

        vecs[0] = '{0, 1'b1, 5'd3,  16'hBEEF, 16'h0000, 16'h0000};
        vecs[1] = '{0, 1'b0, 5'd3,  16'h0000, 16'hBEEF, 16'h0000};
        vecs[2] = '{1, 1'b1, 5'd31, 16'hFFFF, 16'hBEEF, 16'h0000};
        vecs[3] = '{1, 1'b0, 5'd31, 16'h0000, 16'hBEEF, 16'hFFFF};
        vecs[4] = '{1, 1'b1, 5'd5,  16'h00AA, 16'hBEEF, 16'hFFFF};
        vecs[5] = '{1, 1'b0, 5'd5,  16'h0000, 16'hBEEF, 16'h00AA};
        vecs[6] = '{1, 1'b1, 5'd6,  16'h5555, 16'hBEEF, 16'h00AA};
        vecs[7] = '{0, 1'b0, 5'd3,  16'h0000, 16'hBEEF, 16'h00AA};

        reset_n = 1'b1;
        set_req(0, 1'b0, 1'b0, 5'd0, 16'd0);
        set_req(1, 1'b0, 1'b0, 5'd0, 16'd0);
        #2 reset_n = 1'b0;
        #10;
        chk("reset_outs", {14'd0, p0_ack, p1_ack, ram_wr, ram_rd, busy, ram_addr, ram_wdata, p0_rdata},
            64'd0);
        chk("reset_p1_rdata", {48'd0, p1_rdata}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Single-port table: write/read, wrap address, rdata hold
        for (int v = 0; v < 8; v++) begin
            do_txn(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata,
                   (vecs[v].port == 0) ? vecs[v].exp_p0 : vecs[v].exp_p1);
            chk("p0_rdata_hold", {48'd0, p0_rdata}, {48'd0, vecs[v].exp_p0});
            chk("p1_rdata_hold", {48'd0, p1_rdata}, {48'd0, vecs[v].exp_p1});
        end

        // Reset in RD2 of a p1 read
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 5'd31, 16'd0);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rd2_rd_high", {63'd0, ram_rd}, 64'd1);
        chk("rd2_busy", {63'd0, busy}, 64'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_reset_outs", {14'd0, p0_ack, p1_ack, ram_wr, ram_rd, busy, ram_addr, ram_wdata, p0_rdata},
            64'd0);
        chk("async_reset_p1_rdata", {48'd0, p1_rdata}, 64'd0);
        set_req(1, 1'b0, 1'b0, 5'd0, 16'd0);
        nack = 0;
        repeat (3) begin
            @(negedge clk);
            nack += int'(p0_ack | p1_ack);
        end
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            nack += int'(p0_ack | p1_ack);
        end
        chk("no_ack_on_abort", 64'(nack), 64'd0);
        $display("txn reset in RD2 aborted, acks seen=%0d", nack);

        // Simultaneous first request after reset: p0 reads 0, p1 writes 0x1234 to 0
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 5'd0, 16'd0);
        set_req(1, 1'b1, 1'b1, 5'd0, 16'h1234);
        @(posedge clk);
        c0 = 0; c1 = 0; k = 0; r0 = 16'h0;
        while ((c0 == 0 || c1 == 0) && k < 30) begin
            @(negedge clk);
            k++;
            if (p0_ack && c0 == 0) begin
                c0 = k; r0 = p0_rdata;
                set_req(0, 1'b0, 1'b0, 5'd0, 16'd0);
            end
            if (p1_ack && c1 == 0) begin
                c1 = k;
                set_req(1, 1'b0, 1'b0, 5'd0, 16'd0);
            end
        end
        chk("tie_p0_ack_cycle", 64'(c0), 64'd3);
        chk("tie_p1_ack_cycle", 64'(c1), 64'd6);
        chk("tie_p0_old_value", {48'd0, r0}, 64'd0);
        $display("txn tie p0 ack at %0d (rdata=%h), p1 ack at %0d", c0, r0, c1);
        do_txn(0, 1'b0, 5'd0, 16'd0, 16'h1234);

        // Sustained contention: last grant was p0, so p1 goes first
        mon_en = 1'b1;
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 5'd16, 16'hC000);
        set_req(1, 1'b1, 1'b0, 5'd31, 16'd0);
        i0 = 0; i1 = 0; exp_port = 1; k = 0;
        while ((i0 < 8 || i1 < 8) && k < 300) begin
            @(negedge clk);
            k++;
            if (p0_ack) begin
                chk("grant_order", 64'd0, 64'(exp_port));
                exp_port = 1;
                i0++;
                $display("txn contention p0 wr #%0d", i0);
                if (i0 < 8) set_req(0, 1'b1, 1'b1, 5'(16 + i0), 16'hC000 + 16'(i0));
                else        set_req(0, 1'b0, 1'b0, 5'd0, 16'd0);
            end
            if (p1_ack) begin
                chk("grant_order", 64'd1, 64'(exp_port));
                chk("contention_p1_rdata", {48'd0, p1_rdata}, 64'hFFFF);
                exp_port = 0;
                i1++;
                $display("txn contention p1 rd #%0d rdata=%h", i1, p1_rdata);
                if (i1 >= 8) set_req(1, 1'b0, 1'b0, 5'd0, 16'd0);
            end
        end
        chk("contention_p0_count", 64'(i0), 64'd8);
        chk("contention_p1_count", 64'(i1), 64'd8);
        mon_en = 1'b0;
        do_txn(0, 1'b0, 5'd23, 16'd0, 16'hC007);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
